// File: rtl/cm_sort.sv
// cm_sort: pipelined stable odd-even transposition sorter for DCNT unsigned words.
// Latency: exactly REG_CNT cycles, one vector per cycle, back-to-back allowed.
// Backpressure: none; every cycle with i_vld=1 is accepted.
//
// Ports:
//   i_clk, i_rst        rising-edge clock, asynchronous active-high reset
//   i_vld, i_data       input vector strobe and packed words (element 0 = index 0)
//   o_vld, o_data       sorted words, o_data[0] smallest, registered
//   o_idx               original input index of each output word

package cm_pkg;
  // ceil(log2(n)), never less than 1
  function automatic int sclog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

module cm_sort #(
  parameter  int DCNT      = 4,
  parameter  int DWIDTH    = 16,
  parameter  int REG_CNT   = 1,
  localparam int IDX_WIDTH = cm_pkg::sclog2(DCNT)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_vld,
  input  logic [DCNT-1:0][DWIDTH-1:0]        i_data,
  output logic                               o_vld,
  output logic [DCNT-1:0][IDX_WIDTH-1:0]     o_idx,
  output logic [DCNT-1:0][DWIDTH-1:0]        o_data
);

  // Each lane carries {data, idx}; comparison looks only at the data field.
  localparam int LW = DWIDTH + IDX_WIDTH;
  typedef logic [DCNT-1:0][LW-1:0] vec_t;

  // One compare-exchange stage: pairs (j, j+1) with j of the same parity as s.
  // Strict '>' keeps equal words in input order, which makes the sort stable.
  function automatic vec_t cx_stage(input vec_t v, input int s);
    vec_t r;
    r = v;
    for (int j = 0; j < DCNT - 1; j++) begin
      if ((j % 2) == (s % 2)) begin
        if (v[j][LW-1:IDX_WIDTH] > v[j+1][LW-1:IDX_WIDTH]) begin
          r[j]   = v[j+1];
          r[j+1] = v[j];
        end
      end
    end
    return r;
  endfunction

  vec_t lane_init;

  always_comb begin
    lane_init = '0;
    for (int j = 0; j < DCNT; j++) begin
      lane_init[j] = {i_data[j], IDX_WIDTH'(j)};
    end
  end

  // Segment k holds comparator stages [LO, HI) followed by register k+1, so
  // register k+1 sits after stage ceil((k+1)*DCNT/REG_CNT). When REG_CNT
  // exceeds DCNT some segments are empty and act as plain delay registers.
  for (genvar k = 0; k < REG_CNT; k++) begin : g_seg
    localparam int LO = (k * DCNT + REG_CNT - 1) / REG_CNT;
    localparam int HI = ((k + 1) * DCNT + REG_CNT - 1) / REG_CNT;

    vec_t seg_in;
    vec_t seg_out;
    vec_t q;
    logic seg_vld;
    logic v;

    if (k == 0) begin : g_head
      assign seg_in  = lane_init;
      assign seg_vld = i_vld;
    end else begin : g_link
      assign seg_in  = g_seg[k-1].q;
      assign seg_vld = g_seg[k-1].v;
    end

    always_comb begin
      vec_t t;
      t = seg_in;
      for (int s = LO; s < HI; s++) begin
        t = cx_stage(t, s);
      end
      seg_out = t;
    end

    // Data only moves with a valid vector; otherwise it holds its last value.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v <= 1'b0;
        q <= '0;
      end else begin
        v <= seg_vld;
        if (seg_vld) begin
          q <= seg_out;
        end
      end
    end
  end

  assign o_vld = g_seg[REG_CNT-1].v;

  always_comb begin
    o_data = '0;
    o_idx  = '0;
    for (int j = 0; j < DCNT; j++) begin
      o_data[j] = g_seg[REG_CNT-1].q[j][LW-1:IDX_WIDTH];
      o_idx[j]  = g_seg[REG_CNT-1].q[j][IDX_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_cm_sort.sv
// Testbench for cm_sort: four configurations driven from one stimulus vector,
// each checked every cycle against a rank-based stable-sort reference,
// plus directed literal expectations for the documented vectors.
module tb_cm_sort;

  logic             clk = 1'b0;
  logic             rst;
  logic             vld;
  logic [9:0][15:0] stim;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int cfg_dcnt(input int g);
    case (g)
      0: return 4;
      1: return 6;
      2: return 10;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_reg(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int D  = cfg_dcnt(g);
    localparam int R  = cfg_reg(g);
    localparam int IW = $clog2(D);

    logic [D-1:0][15:0]   in_data;
    logic [D-1:0][15:0]   o_data;
    logic [D-1:0][IW-1:0] o_idx;
    logic                 o_vld;

    assign in_data = stim[D-1:0];

    cm_sort #(.DCNT(D), .DWIDTH(16), .REG_CNT(R)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .i_vld (vld),
      .i_data(in_data),
      .o_vld (o_vld),
      .o_idx (o_idx),
      .o_data(o_data)
    );

    int pcount  = 0;
    int n_in    = 0;
    int n_out   = 0;
    int n_flush = 0;
    int                   due_q[$];
    logic [D-1:0][15:0]   ed_q[$];
    logic [D-1:0][IW-1:0] ei_q[$];
    logic [D-1:0][15:0]   in_q[$];

    // Reference: a word's output position is the number of words smaller
    // than it plus the number of equal words at lower input index.
    always @(posedge clk or posedge rst) begin
      logic [D-1:0][15:0]   sd;
      logic [D-1:0][IW-1:0] si;
      int rank;
      if (rst) begin
        n_flush += due_q.size();
        due_q.delete();
        ed_q.delete();
        ei_q.delete();
        in_q.delete();
      end else begin
        pcount++;
        if (vld) begin
          sd = '0;
          si = '0;
          for (int i = 0; i < D; i++) begin
            rank = 0;
            for (int j = 0; j < D; j++) begin
              if (in_data[j] < in_data[i] || (in_data[j] == in_data[i] && j < i)) rank++;
            end
            sd[rank] = in_data[i];
            si[rank] = IW'(i);
          end
          due_q.push_back(pcount + R - 1);
          ed_q.push_back(sd);
          ei_q.push_back(si);
          in_q.push_back(in_data);
          n_in++;
        end
      end
    end

    always @(negedge clk) begin
      logic ev;
      logic ok;
      if (!rst) begin
        ev = (due_q.size() > 0) && (due_q[0] == pcount);
        if (o_vld === 1'b1) n_out++;
        chk($sformatf("cfg%0d o_vld", g), o_vld, ev);
        if (ev) begin
          chk($sformatf("cfg%0d o_data", g), o_data, ed_q[0]);
          chk($sformatf("cfg%0d o_idx", g), o_idx, ei_q[0]);
          ok = 1'b1;
          for (int k = 0; k < D; k++) begin
            if (!(int'(o_idx[k]) < D)) ok = 1'b0;
            else if (o_data[k] !== in_q[0][o_idx[k]]) ok = 1'b0;
          end
          chk($sformatf("cfg%0d data_at_idx", g), ok, 1'b1);
          void'(due_q.pop_front());
          void'(ed_q.pop_front());
          void'(ei_q.pop_front());
          void'(in_q.pop_front());
        end
      end
    end
  end

  task automatic pulse(input logic [9:0][15:0] v);
    @(posedge clk);
    #2;
    stim = v;
    vld  = 1'b1;
    @(posedge clk);
    #2;
    vld  = 1'b0;
  endtask

  initial begin
    logic [9:0][15:0] v;
    logic [9:0][15:0] exd;
    logic [9:0][3:0]  exi;

    rst  = 1'b0;
    vld  = 1'b0;
    stim = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset cfg0 o_vld", g_cfg[0].o_vld, 1'b0);
    chk("reset cfg1 o_vld", g_cfg[1].o_vld, 1'b0);
    chk("reset cfg2 o_vld", g_cfg[2].o_vld, 1'b0);
    chk("reset cfg3 o_vld", g_cfg[3].o_vld, 1'b0);
    chk("reset cfg2 o_data", g_cfg[2].o_data, '0);
    chk("reset cfg2 o_idx", g_cfg[2].o_idx, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    // DCNT=4, REG_CNT=1 directed vector
    v = '0;
    v[0] = 16'h0030; v[1] = 16'h0010; v[2] = 16'h0040; v[3] = 16'h0020;
    pulse(v);
    #1;
    chk("t1 cfg0 o_vld", g_cfg[0].o_vld, 1'b1);
    chk("t1 cfg0 o_data", g_cfg[0].o_data, {16'h0040, 16'h0030, 16'h0020, 16'h0010});
    chk("t1 cfg0 o_idx", g_cfg[0].o_idx, {2'd2, 2'd0, 2'd3, 2'd1});
    @(posedge clk); #1;
    chk("t1 cfg0 o_vld single", g_cfg[0].o_vld, 1'b0);

    // DCNT=6, REG_CNT=2: all-ones words sort last, ties stay in order
    v = '0;
    v[0] = 16'hFFFF; v[1] = 16'd7; v[2] = 16'hFFFF; v[3] = 16'd3; v[4] = 16'hFFFF; v[5] = 16'd5;
    pulse(v);
    #1;
    chk("t2 cfg1 o_vld early", g_cfg[1].o_vld, 1'b0);
    @(posedge clk); #1;
    chk("t2 cfg1 o_vld", g_cfg[1].o_vld, 1'b1);
    chk("t2 cfg1 o_data", g_cfg[1].o_data,
        {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd7, 16'd5, 16'd3});
    chk("t2 cfg1 o_idx", g_cfg[1].o_idx, {3'd4, 3'd2, 3'd0, 3'd1, 3'd5, 3'd3});

    // DCNT=10, REG_CNT=4: reverse-sorted input
    for (int k = 0; k < 10; k++) begin
      v[k]   = 16'(9 - k);
      exd[k] = 16'(k);
      exi[k] = 4'(9 - k);
    end
    pulse(v);
    repeat (2) @(posedge clk); #1;
    chk("t3 cfg2 o_vld early", g_cfg[2].o_vld, 1'b0);
    @(posedge clk); #1;
    chk("t3 cfg2 o_vld", g_cfg[2].o_vld, 1'b1);
    chk("t3 cfg2 o_data", g_cfg[2].o_data, exd);
    chk("t3 cfg2 o_idx", g_cfg[2].o_idx, exi);
    @(posedge clk); #1;
    chk("t3 cfg2 o_vld single", g_cfg[2].o_vld, 1'b0);

    // all-equal words: identity index
    for (int k = 0; k < 10; k++) begin
      v[k]   = 16'h1234;
      exi[k] = 4'(k);
    end
    pulse(v);
    repeat (3) @(posedge clk); #1;
    chk("t4 cfg2 o_data", g_cfg[2].o_data, v);
    chk("t4 cfg2 o_idx", g_cfg[2].o_idx, exi);

    // 20 back-to-back random vectors with frequent ties and all-ones words
    @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      #2;
      for (int k = 0; k < 10; k++) begin
        case ($urandom_range(0, 3))
          0:       stim[k] = 16'hFFFF;
          1:       stim[k] = 16'($urandom_range(0, 3));
          default: stim[k] = 16'($urandom);
        endcase
      end
      vld = 1'b1;
      @(posedge clk);
    end
    #2 vld = 1'b0;
    repeat (6) @(posedge clk);

    // DCNT=8, REG_CNT=3: reset while a vector is in flight
    for (int k = 0; k < 10; k++) v[k] = 16'(100 - 7 * k);
    pulse(v);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t6 cfg3 o_vld async", g_cfg[3].o_vld, 1'b0);
    chk("t6 cfg3 o_data cleared", g_cfg[3].o_data, '0);
    chk("t6 cfg3 o_idx cleared", g_cfg[3].o_idx, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    pulse(v);
    @(posedge clk); #1;
    chk("t6 cfg3 o_vld early", g_cfg[3].o_vld, 1'b0);
    @(posedge clk); #1;
    chk("t6 cfg3 o_vld", g_cfg[3].o_vld, 1'b1);
    repeat (6) @(posedge clk);

    chk("cfg0 vld count", g_cfg[0].n_out, g_cfg[0].n_in - g_cfg[0].n_flush);
    chk("cfg1 vld count", g_cfg[1].n_out, g_cfg[1].n_in - g_cfg[1].n_flush);
    chk("cfg2 vld count", g_cfg[2].n_out, g_cfg[2].n_in - g_cfg[2].n_flush);
    chk("cfg3 vld count", g_cfg[3].n_out, g_cfg[3].n_in - g_cfg[3].n_flush);
    chk("cfg3 flushed", g_cfg[3].n_flush, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
